// File: rtl/btn_pkg.sv
// Shared types and width helpers for the time-shared button debouncer.
package btn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Index width, never narrower than 1 bit so a single-button build still has an idx register.
  function automatic int idx_w(input int num_btn);
    return (num_btn > 1) ? $clog2(num_btn) : 1;
  endfunction

  function automatic int cnt_w(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Free-running sample-tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = cnt_w(TICK_DIV);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/btn_scan_debounce.sv
// Round-robin debouncer: one history/evaluate datapath shared across all buttons per sample tick.
// Optional btn_release output is built when BTN_RELEASE_EN is defined.
//
// state | meaning
// IDLE  | waiting for the next sample tick
// SCAN  | one button per cycle: shift in its synchronized sample, apply hysteresis
module btn_scan_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN  = 4,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               scan_busy
`ifdef BTN_RELEASE_EN
  ,
  output logic [NUM_BTN-1:0] btn_release
`endif
);

  localparam int IDX_W = idx_w(NUM_BTN);

  if (TICK_DIV < NUM_BTN + 2) begin : g_bad_tick_div
    $error("btn_scan_debounce: TICK_DIV must be >= NUM_BTN+2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("btn_scan_debounce: DEPTH must be >= 2");
  end
  if (NUM_BTN < 1) begin : g_bad_num_btn
    $error("btn_scan_debounce: NUM_BTN must be >= 1");
  end

  logic               tick;
  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync_q;

  scan_state_t        state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;

  logic [DEPTH-1:0]   hist [NUM_BTN];
  logic [DEPTH-1:0]   hist_shift;
  logic               all_ones, all_zeros;

  btn_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (idx == IDX_W'(NUM_BTN - 1)) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign scan_busy  = (state == SCAN);
  assign hist_shift = {hist[idx][DEPTH-2:0], sync_q[idx]};
  assign all_ones   = &hist_shift;
  assign all_zeros  = ~|hist_shift;

  // Hysteresis: level only moves on a full run of agreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '{default: '0};
      btn_level <= '0;
      btn_press <= '0;
`ifdef BTN_RELEASE_EN
      btn_release <= '0;
`endif
    end else begin
      btn_press <= '0;
`ifdef BTN_RELEASE_EN
      btn_release <= '0;
`endif
      if (state == SCAN) begin
        hist[idx] <= hist_shift;
        if (all_ones && !btn_level[idx]) begin
          btn_level[idx] <= 1'b1;
          btn_press[idx] <= 1'b1;
        end else if (all_zeros && btn_level[idx]) begin
          btn_level[idx] <= 1'b0;
`ifdef BTN_RELEASE_EN
          btn_release[idx] <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_scan_debounce.sv
// Directed bench for btn_scan_debounce with NUM_BTN=4, DEPTH=4, TICK_DIV=8.
// Exercises release pulses as well when BTN_RELEASE_EN is defined.
module tb_btn_scan_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       scan_busy;
`ifdef BTN_RELEASE_EN
  logic [3:0] btn_release;
`endif

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  btn_scan_debounce #(
    .NUM_BTN (4),
    .DEPTH   (4),
    .TICK_DIV(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .scan_busy(scan_busy)
`ifdef BTN_RELEASE_EN
    ,
    .btn_release(btn_release)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number e counted from reset release.
  task automatic goto(input int e);
    if (e <= ecount) begin
      tests++;
      fails++;
      $error("FAIL goto: at edge %0d expected to reach edge %0d", ecount, e);
    end else begin
      while (ecount < e) begin
        @(posedge clk);
        ecount++;
      end
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] raw);
    btn_raw = raw;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_press", 32'(btn_press), 32'h0);
    check("rst_busy", 32'(scan_busy), 32'h0);
    reset  = 1'b0;
    ecount = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bounce_pat [12];
    bounce_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values, first scan window, steady press on btn2.
    do_reset(4'b0100);
    goto(7);
    check("busy_pre_tick", 32'(scan_busy), 32'h0);
    goto(8);
    check("busy_first", 32'(scan_busy), 32'h1);
    check("level_first", 32'(btn_level), 32'h0);
    goto(11);
    check("busy_last", 32'(scan_busy), 32'h1);
    goto(12);
    check("busy_end", 32'(scan_busy), 32'h0);
    goto(34);
    check("steady_level_pre", 32'(btn_level), 32'h0);
    check("steady_press_pre", 32'(btn_press), 32'h0);
    goto(35);
    check("steady_level", 32'(btn_level), 32'h4);
    check("steady_press", 32'(btn_press), 32'h4);
    for (int e = 36; e <= 60; e++) begin
      goto(e);
      check("steady_no_repress", 32'(btn_press), 32'h0);
    end
    check("steady_level_held", 32'(btn_level), 32'h4);

    // Bounce on btn0: 1,0,1,1,1,1 then 0,1,0,0,0,0.
    do_reset(4'b0000);
    for (int k = 1; k <= 12; k++) begin
      goto(8 * k - 4);
      btn_raw[0] = bounce_pat[k-1];
      goto(8 * k + 1);
      check("bounce_level", 32'(btn_level), (k >= 6 && k < 12) ? 32'h1 : 32'h0);
      check("bounce_press", 32'(btn_press), (k == 6) ? 32'h1 : 32'h0);
`ifdef BTN_RELEASE_EN
      check("bounce_release", 32'(btn_release), (k == 12) ? 32'h1 : 32'h0);
`endif
    end

    // All buttons together: press pulses walk one bit per cycle.
    do_reset(4'b1111);
    goto(32);
    check("simul_press_pre", 32'(btn_press), 32'h0);
    for (int i = 0; i < 4; i++) begin
      goto(33 + i);
      check("simul_press", 32'(btn_press), 32'h1 << i);
    end
    check("simul_level", 32'(btn_level), 32'hF);
    goto(37);
    check("simul_press_post", 32'(btn_press), 32'h0);

    // Reset asserted in the 2nd SCAN cycle of tick 4, btn1 holding 3 ones.
    do_reset(4'b0011);
    goto(26);
    check("mid_level_pre", 32'(btn_level), 32'h0);
    goto(33);
    check("mid_level_b0", 32'(btn_level), 32'h1);
    check("mid_press_b0", 32'(btn_press), 32'h1);
    check("mid_busy", 32'(scan_busy), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_clr_level", 32'(btn_level), 32'h0);
    check("mid_clr_press", 32'(btn_press), 32'h0);
    check("mid_clr_busy", 32'(scan_busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    ecount = 0;
    goto(26);
    check("mid_after_t3", 32'(btn_level), 32'h0);
    goto(33);
    check("mid_after_b0", 32'(btn_level), 32'h1);
    goto(34);
    check("mid_after_b1", 32'(btn_level), 32'h3);
    check("mid_after_press", 32'(btn_press), 32'h2);

    // Release of held btn3 after four zero samples.
    do_reset(4'b1000);
    goto(36);
    check("rel_level_up", 32'(btn_level), 32'h8);
    check("rel_press", 32'(btn_press), 32'h8);
    btn_raw = 4'b0000;
    goto(60);
    check("rel_level_t7", 32'(btn_level), 32'h8);
    goto(67);
    check("rel_level_pre", 32'(btn_level), 32'h8);
`ifdef BTN_RELEASE_EN
    check("rel_pulse_pre", 32'(btn_release), 32'h0);
`endif
    goto(68);
    check("rel_level_down", 32'(btn_level), 32'h0);
`ifdef BTN_RELEASE_EN
    check("rel_pulse", 32'(btn_release), 32'h8);
`endif
    goto(69);
    check("rel_press_none", 32'(btn_press), 32'h0);
`ifdef BTN_RELEASE_EN
    check("rel_pulse_post", 32'(btn_release), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
